// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and parameter defaults for the memory-stage controller
package mem_stage_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT_R = 2'b10} memState_t;
    localparam int DATA_W_DEF = 32;
    localparam int TIMEOUT_CYC_DEF = 64;
endpackage

// File: rtl/mem_stage_ctrl_flop_mw.sv
// flop_mw: M/W pipeline register with load-enable and bubble insertion, reset value 0
module flop_mw #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic              loadRead,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] ReadDataM,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            {PCSrcW, RegWriteW, MemtoRegW} <= 3'b000;
            ReadDataW <= '0;
            ALUOutW <= '0;
        end else if (bubble) begin
            {PCSrcW, RegWriteW, MemtoRegW} <= 3'b000;
        end else if (load) begin
            {PCSrcW, RegWriteW, MemtoRegW} <= {PCSrcM, RegWriteM, MemtoRegM};
            ALUOutW <= ALUResultM;
            if (loadRead) ReadDataW <= ReadDataM;
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage FSM for a handshaked data memory; drives StallM and the M/W register.
// Optional watchdog (TIMEOUT_CYC parameter, sticky mem_err port) when MEM_TIMEOUT_EN is defined.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW
`ifdef MEM_TIMEOUT_EN
    , output logic            mem_err
`endif
);
    memState_t state, stateNext;
    logic memop, done, loadRead, tmo;
    logic [DATA_W-1:0] readData;

    assign memop = MemWriteM | MemtoRegM;
    assign mem_we = MemWriteM;
    assign mem_addr = ALUResultM;
    assign mem_wdata = WriteDataM;
    assign StallM = memop & ~done;
    assign loadRead = ((state == WAIT_R) & mem_rvalid) | tmo;
    assign readData = tmo ? '0 : mem_rdata;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    // cnt holds the stalled cycles already spent; the access is forced done on the
    // cycle whose closing edge would bring it to TIMEOUT_CYC
    assign tmo = (state != IDLE) & (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            cnt <= !StallM ? '0 : (stateNext != state) ? CNT_W'(1) : cnt + 1'b1;
            mem_err <= mem_err | tmo;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        done = 1'b0;
        mem_req = 1'b0;
        case (state)
            IDLE, REQ: begin
                mem_req = (state == REQ) | memop;
                if (memop && mem_gnt) begin
                    done = MemWriteM;
                    stateNext = MemWriteM ? IDLE : WAIT_R;
                end else if (memop) begin
                    stateNext = REQ;
                end
            end
            WAIT_R: begin
                done = mem_rvalid;
                stateNext = mem_rvalid ? IDLE : WAIT_R;
            end
            default: stateNext = IDLE;
        endcase
        if (tmo) begin
            done = 1'b1;
            mem_req = 1'b0;
            stateNext = IDLE;
        end
    end

    flop_mw #(.DATA_W(DATA_W)) mwReg (
        .clk(clk),
        .reset(reset),
        .load(~StallM),
        .bubble(StallM),
        .loadRead(loadRead),
        .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM),
        .ReadDataM(readData),
        .PCSrcW(PCSrcW),
        .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW)
    );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl; timeout tests build when MEM_TIMEOUT_EN is defined
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic PCSrcM = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic StallM, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic PCSrcW, RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
`ifdef MEM_TIMEOUT_EN
    localparam int TO_CYC = 4;
    logic mem_err;
`endif
    int vectors = 0, miscompares = 0;
    logic [66:0] sbq[$];
    logic [66:0] lastW = '0;
    logic [31:0] shadowRd = '0;
    logic [66:0] wBus;

    assign wBus = {PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW};

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W(32)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .StallM(StallM),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .PCSrcW(PCSrcW),
        .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW)
`ifdef MEM_TIMEOUT_EN
        , .mem_err(mem_err)
`endif
    );

    task automatic checkVec(input string tag, input logic [66:0] got, input logic [66:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One instruction held in M until completion; gDly cycles without grant, rvalid rDly cycles after grant.
    // stallExp < 0 derives the stall count from the handshake schedule.
    task automatic runInstr(input logic pcs, input logic rw, input logic m2r, input logic mw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rd,
                            input int gDly, input int rDly, input int stallExp);
        logic isMem, isLoad, granted, done;
        int gCyc, stalls, expStalls;
        logic [66:0] e;
        isMem = m2r | mw;
        isLoad = m2r & ~mw;
        expStalls = (stallExp >= 0) ? stallExp : isMem ? gDly + (isLoad ? rDly : 0) : 0;
        if (isLoad) shadowRd = rd;
        sbq.push_back({pcs, rw, m2r, shadowRd, alu});
        {PCSrcM, RegWriteM, MemtoRegM, MemWriteM} = {pcs, rw, m2r, mw};
        ALUResultM = alu;
        WriteDataM = wd;
        granted = 1'b0;
        done = 1'b0;
        gCyc = 0;
        stalls = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            mem_gnt = granted ? (isLoad && 1'($urandom_range(0, 1))) : (isMem && c >= gDly);
            mem_rvalid = (isLoad && granted) ? (c == gCyc + rDly) : 1'($urandom_range(0, 1));
            mem_rdata = (isLoad && mem_rvalid) ? rd : $urandom;
            @(negedge clk);
            if (c == 0 && isMem) checkVec("memreq", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, mw, alu, wd});
            if (granted) checkVec("req_wait", 67'(mem_req), 67'(0));
            if (!StallM) done = 1'b1;
            else stalls++;
            if (mem_gnt && !granted) begin
                granted = 1'b1;
                gCyc = c;
            end
            @(posedge clk);
            #1;
            if (done) begin
                e = sbq.pop_front();
                checkVec("wb", wBus, e);
                lastW = e;
            end else begin
                checkVec("bubble", wBus, {3'b000, lastW[63:0]});
            end
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        checkVec("done", 67'(done), 67'(1));
        if (!done) sbq.delete();
        checkVec("stalls", 67'(stalls), 67'(expStalls));
    endtask

    initial begin
        int kind;
        logic [66:0] e;
        repeat (2) @(posedge clk);
        #1;
        checkVec("reset_w", wBus, '0);
        checkVec("reset_stall", 67'(StallM), 67'(0));
        reset = 1'b1;

        runInstr(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 0, -1);
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD, 32'h0, 0, 0, -1);
        runInstr(1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 32'h1234, 2, 3, 5);
        runInstr(1'b1, 1'b0, 1'b0, 1'b0, 32'h99, 32'h0, 32'h0, 0, 0, -1);
        runInstr(1'b0, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 32'hCAFE, 0, 1, 1);
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'hA4, 32'h5555, 32'h0, 0, 0, 0);
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'hB0, 32'h77, 32'h0, 3, 0, 3);

        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 2);
            runInstr(1'($urandom_range(0, 1)), kind != 1, kind == 2, kind == 1, $urandom, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(1, 3), -1);
        end

        // reset while waiting for load data; the late rvalid must not reach W
        {PCSrcM, RegWriteM, MemtoRegM, MemWriteM} = 4'b0110;
        ALUResultM = 32'h100;
        mem_gnt = 1'b1;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        lastW = '0;
        shadowRd = '0;
        checkVec("rst_w", wBus, '0);
        {PCSrcM, RegWriteM, MemtoRegM, MemWriteM} = 4'b0100;
        ALUResultM = 32'h55;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD;
        @(negedge clk);
        checkVec("rst_stall", 67'(StallM), 67'(0));
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        e = {3'b010, 32'h0, 32'h55};
        checkVec("rst_next", wBus, e);
        lastW = e;
        runInstr(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 32'h4321, 1, 2, -1);

`ifdef MEM_TIMEOUT_EN
        checkVec("err0", 67'(mem_err), 67'(0));
        runInstr(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 999, 1, TO_CYC - 1);
        checkVec("err_set", 67'(mem_err), 67'(1));
        runInstr(1'b0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0, 0, 0, -1);
        checkVec("err_sticky", 67'(mem_err), 67'(1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkVec("err_clr", 67'(mem_err), 67'(0));
`endif

        checkVec("sb_empty", 67'(sbq.size()), 67'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
